// File: rtl/mp3_display_timing.sv
// ---------------------------------------------------------------------------
// mp3_display_timing
//
// Pixel-coordinate generator for the MP3 player display renderer. Produces
// signed 16-bit coordinates that are negative during blanking, so the active
// area always starts at (0,0). Runs on the system clock and uses a one-cycle
// pixel tick (o_pix_en) from an internal divider.
//
// Optional feature macro: MP3_DISPLAY_TIMING_FRAME_CNT_EN
//   When defined, adds o_frame_cnt, a free-running 16-bit count of o_frame
//   pulses. It is used by the display to time highlight blink/fade effects.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   o_pix_en     out  one-clk pixel tick
//   o_x, o_y     out  signed 16-bit coordinates of the current pixel
//   o_de         out  active-area flag for (o_x,o_y)
//   o_hsync      out  hsync for the current position
//   o_vsync      out  vsync for the current position
//   o_line       out  line-start pulse (pixel tick at o_x == H_STA)
//   o_frame      out  frame-start pulse (line start at o_y == V_STA)
//   o_de_d       out  o_de delayed PIPE clk
//   o_hsync_d    out  o_hsync delayed PIPE clk
//   o_vsync_d    out  o_vsync delayed PIPE clk
//   o_frame_cnt  out  frame counter (only with the macro defined)
// ---------------------------------------------------------------------------
module mp3_display_timing #(
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int PIX_DIV = 4,
  parameter int PIPE    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_pix_en,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic               o_de,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_line,
  output logic               o_frame,
  output logic               o_de_d,
  output logic               o_hsync_d,
  output logic               o_vsync_d
`ifdef MP3_DISPLAY_TIMING_FRAME_CNT_EN
  ,
  output logic        [15:0] o_frame_cnt
`endif
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;

  localparam logic signed [15:0] H_STA      = 16'(-H_BLANK);
  localparam logic signed [15:0] H_SYNC_BEG = 16'(H_FP - H_BLANK);
  localparam logic signed [15:0] H_SYNC_END = 16'(H_FP + H_SYNC - 1 - H_BLANK);
  localparam logic signed [15:0] X_LAST     = 16'(H_RES - 1);

  localparam logic signed [15:0] V_STA      = 16'(-V_BLANK);
  localparam logic signed [15:0] V_SYNC_BEG = 16'(V_FP - V_BLANK);
  localparam logic signed [15:0] V_SYNC_END = 16'(V_FP + V_SYNC - 1 - V_BLANK);
  localparam logic signed [15:0] Y_LAST     = 16'(V_RES - 1);

  localparam logic HS_ON  = (H_POL != 0);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = (V_POL != 0);
  localparam logic VS_OFF = ~VS_ON;

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  // Elaboration-time parameter sanity checks.
  if ((H_RES + H_BLANK) > 32767) begin : g_chk_htotal
    $error("mp3_display_timing: horizontal total exceeds 32767");
  end
  if ((V_RES + V_BLANK) > 32767) begin : g_chk_vtotal
    $error("mp3_display_timing: vertical total exceeds 32767");
  end
  if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_chk_div
    $error("mp3_display_timing: PIX_DIV must be 1..16");
  end
  if ((PIPE < 0) || (PIPE > 8)) begin : g_chk_pipe
    $error("mp3_display_timing: PIPE must be 0..8");
  end

  logic        [3:0]  div_cnt;
  logic signed [15:0] next_x;
  logic signed [15:0] next_y;

  // The tick is registered from the divider's terminal count, so the first
  // tick after reset lands exactly PIX_DIV clocks later and PIX_DIV=1 gives
  // a constant-high tick without glitching high during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      o_pix_en <= 1'b0;
    end else begin
      o_pix_en <= (div_cnt == DIV_LAST);
      div_cnt  <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end
  end

  always_comb begin
    next_x = o_x;
    next_y = o_y;
    if (o_pix_en) begin
      if (o_x == X_LAST) begin
        next_x = H_STA;
        next_y = (o_y == Y_LAST) ? V_STA : o_y + 16'sd1;
      end else begin
        next_x = o_x + 16'sd1;
      end
    end
  end

  // Flags are decoded from the next coordinates so they change on the same
  // edge as o_x/o_y and always describe the position currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_x     <= H_STA;
      o_y     <= V_STA;
      o_de    <= 1'b0;
      o_hsync <= HS_OFF;
      o_vsync <= VS_OFF;
    end else begin
      o_x     <= next_x;
      o_y     <= next_y;
      o_de    <= (next_x >= 16'sd0) && (next_y >= 16'sd0);
      o_hsync <= ((next_x >= H_SYNC_BEG) && (next_x <= H_SYNC_END)) ? HS_ON : HS_OFF;
      o_vsync <= ((next_y >= V_SYNC_BEG) && (next_y <= V_SYNC_END)) ? VS_ON : VS_OFF;
    end
  end

  assign o_line  = o_pix_en && (o_x == H_STA);
  assign o_frame = o_line && (o_y == V_STA);

  // Delay line aligning sync/DE with the renderer's registered RGB.
  if (PIPE == 0) begin : g_nopipe
    assign o_de_d    = o_de;
    assign o_hsync_d = o_hsync;
    assign o_vsync_d = o_vsync;
  end else begin : g_pipe
    logic [PIPE-1:0] de_sr;
    logic [PIPE-1:0] hs_sr;
    logic [PIPE-1:0] vs_sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        de_sr <= '0;
        hs_sr <= {PIPE{HS_OFF}};
        vs_sr <= {PIPE{VS_OFF}};
      end else begin
        de_sr <= PIPE'({de_sr, o_de});
        hs_sr <= PIPE'({hs_sr, o_hsync});
        vs_sr <= PIPE'({vs_sr, o_vsync});
      end
    end

    assign o_de_d    = de_sr[PIPE-1];
    assign o_hsync_d = hs_sr[PIPE-1];
    assign o_vsync_d = vs_sr[PIPE-1];
  end

`ifdef MP3_DISPLAY_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_cnt <= '0;
    end else if (o_frame) begin
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end
`endif

endmodule
